// File: rtl/trace_pkg.sv
// Shared trace definitions: word width, buffer geometry defaults and the frame-header
// bit layout agreed with the SPI slave.
package trace_pkg;

  localparam int TRACE_WORD_W         = 16;
  localparam int FRAME_WORDS_DEFAULT  = 8;
  localparam int DEPTH_FRAMES_DEFAULT = 4;

  typedef logic [TRACE_WORD_W-1:0] trace_word_t;

  // Frame header layout as seen by the SPI slave
  localparam int HDR_VALID_BIT = 15;
  localparam int HDR_SYNC_BIT  = 14;
  localparam int HDR_WIDTH_MSB = 13;
  localparam int HDR_WIDTH_LSB = 8;

endpackage

// File: rtl/trace_frame_buffer_if.sv
// Signal bundle between the trace assembler / SPI slave side and trace_frame_buffer.
// Optional statistics signals appear when TRACE_FRAME_BUFFER_STATS_EN is defined.
interface trace_frame_buffer_if
  import trace_pkg::*;
#(
    parameter int DEPTH_FRAMES = DEPTH_FRAMES_DEFAULT
);
    localparam int FH_W = $clog2(DEPTH_FRAMES) + 1;

    trace_word_t       traceWord;
    logic              traceValid;
    logic              sync;
    logic              tx_free;
    logic              rxFrameReset;
    trace_word_t       tx_word;
    logic              transmitIn;
    logic              overflow;
    logic [FH_W-1:0]   framesHeld;
`ifdef TRACE_FRAME_BUFFER_STATS_EN
    logic [15:0]       dropCount;
    logic [FH_W-1:0]   hwmFrames;
`endif

    modport master (
        output traceWord, traceValid, sync, tx_free, rxFrameReset,
        input  tx_word, transmitIn, overflow, framesHeld
`ifdef TRACE_FRAME_BUFFER_STATS_EN
        , input dropCount, hwmFrames
`endif
    );

    modport slave (
        input  traceWord, traceValid, sync, tx_free, rxFrameReset,
        output tx_word, transmitIn, overflow, framesHeld
`ifdef TRACE_FRAME_BUFFER_STATS_EN
        , output dropCount, hwmFrames
`endif
    );

endinterface

// File: rtl/pulse_sync.sv
// Two-flop synchroniser for an asynchronous level, followed by a registered
// rising-edge detect: one clk-wide pulse three clocks after the level rises.
module pulse_sync (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic meta_p0;
    logic stable_p1;
    logic prev_p2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_p0   <= 1'b0;
            stable_p1 <= 1'b0;
            prev_p2   <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            meta_p0   <= level;
            // stage boundary: synchronised level into edge detect
            stable_p1 <= meta_p0;
            prev_p2   <= stable_p1;
            pulse     <= stable_p1 & ~prev_p2;
        end
    end

endmodule

// File: rtl/trace_frame_buffer.sv
// Frame-granular trace FIFO between the word assembler and the SPI slave link.
// Define TRACE_FRAME_BUFFER_STATS_EN to add dropCount / hwmFrames statistics.
module trace_frame_buffer
  import trace_pkg::*;
#(
    parameter int FRAME_WORDS  = FRAME_WORDS_DEFAULT,
    parameter int DEPTH_FRAMES = DEPTH_FRAMES_DEFAULT
) (
    input logic                 clk,
    input logic                 rst,
    trace_frame_buffer_if.slave bus
);

    localparam int ADDR_W = $clog2(FRAME_WORDS * DEPTH_FRAMES);
    localparam int IDX_W  = $clog2(FRAME_WORDS);
    localparam int FRM_W  = $clog2(DEPTH_FRAMES);
    localparam int FH_W   = FRM_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);
    localparam logic [FH_W-1:0]  FULL     = FH_W'(DEPTH_FRAMES);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    trace_word_t mem [FRAME_WORDS*DEPTH_FRAMES];

    logic [IDX_W-1:0] wr_idx, wr_idx_nx, rd_idx, rd_idx_nx;
    logic [FRM_W-1:0] wr_frame, wr_frame_nx, rd_frame, rd_frame_nx;
    logic [FH_W-1:0]  held, held_nx;
    logic             dropping, dropping_nx;
    logic             commit, release_f, drop_start, drop_now, mem_we;
    logic             free_pulse, rrst_pulse;
    logic             overflow_q, transmit_q;
    trace_word_t      tx_word_q;
    logic [ADDR_W-1:0] wr_addr, rd_addr_nx;

    pulse_sync u_free_sync (.clk(clk), .rst(rst), .level(bus.tx_free),      .pulse(free_pulse));
    pulse_sync u_rrst_sync (.clk(clk), .rst(rst), .level(bus.rxFrameReset), .pulse(rrst_pulse));

    always_comb begin
        wr_idx_nx   = wr_idx;
        wr_frame_nx = wr_frame;
        dropping_nx = dropping;
        commit      = 1'b0;
        drop_start  = 1'b0;
        drop_now    = 1'b0;
        mem_we      = 1'b0;
        rd_idx_nx   = rd_idx;
        rd_frame_nx = rd_frame;
        release_f   = 1'b0;
        held_nx     = held;

        // Full is judged only at frame start so a started frame always completes
        if (!bus.sync) begin
            wr_idx_nx   = '0;
            dropping_nx = 1'b0;
        end else if (bus.traceValid) begin
            drop_start = (wr_idx == '0) && (held == FULL);
            drop_now   = dropping || drop_start;
            mem_we     = !drop_now;
            if (wr_idx == LAST_IDX) begin
                wr_idx_nx   = '0;
                dropping_nx = 1'b0;
                if (!drop_now) begin
                    commit      = 1'b1;
                    wr_frame_nx = wr_frame + 1'b1;
                end
            end else begin
                wr_idx_nx   = wr_idx + 1'b1;
                dropping_nx = drop_now;
            end
        end

        if (rrst_pulse) begin
            rd_idx_nx = '0;
        end else if (free_pulse && (held != '0)) begin
            if (rd_idx == LAST_IDX) begin
                rd_idx_nx   = '0;
                rd_frame_nx = rd_frame + 1'b1;
                release_f   = 1'b1;
            end else begin
                rd_idx_nx = rd_idx + 1'b1;
            end
        end

        if (commit && !release_f)      held_nx = held + 1'b1;
        else if (!commit && release_f) held_nx = held - 1'b1;
    end

    assign wr_addr    = {wr_frame, wr_idx};
    assign rd_addr_nx = {rd_frame_nx, rd_idx_nx};

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_addr] <= bus.traceWord;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_idx     <= '0;
            wr_frame   <= '0;
            rd_idx     <= '0;
            rd_frame   <= '0;
            held       <= '0;
            dropping   <= 1'b0;
            overflow_q <= 1'b0;
            transmit_q <= 1'b0;
            tx_word_q  <= '0;
        end else begin
            wr_idx     <= wr_idx_nx;
            wr_frame   <= wr_frame_nx;
            rd_idx     <= rd_idx_nx;
            rd_frame   <= rd_frame_nx;
            held       <= held_nx;
            dropping   <= dropping_nx;
            transmit_q <= (held_nx != '0);
            if (drop_start) overflow_q <= 1'b1;
            // Empty buffer: keep presenting the last word
            if (held_nx != '0) tx_word_q <= mem[rd_addr_nx];
        end
    end

    assign bus.tx_word    = tx_word_q;
    assign bus.transmitIn = transmit_q;
    assign bus.overflow   = overflow_q;
    assign bus.framesHeld = held;

`ifdef TRACE_FRAME_BUFFER_STATS_EN
    logic [15:0]     drop_cnt;
    logic [FH_W-1:0] hwm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
            hwm      <= '0;
        end else begin
            if (drop_start)    drop_cnt <= sat_inc16(drop_cnt);
            if (held_nx > hwm) hwm      <= held_nx;
        end
    end

    assign bus.dropCount = drop_cnt;
    assign bus.hwmFrames = hwm;
`endif

endmodule

// File: tb/tb_trace_frame_buffer.sv
// Directed, table-driven bench for trace_frame_buffer plus hand-written corner sequences.
module tb_trace_frame_buffer;

    typedef enum logic [1:0] {OP_WR, OP_FREE, OP_RRST, OP_NOSYNC} op_e;

    typedef struct {
        op_e         op;
        logic [15:0] data;
        logic [15:0] exp_word;
        logic        exp_ti;
        logic [2:0]  exp_held;
        logic        exp_ovf;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t vecs[$];

    trace_frame_buffer_if #(.DEPTH_FRAMES(4)) bus ();

    trace_frame_buffer #(.FRAME_WORDS(8), .DEPTH_FRAMES(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic void add(input op_e op, input logic [15:0] d, input logic [15:0] w,
                                input logic ti, input logic [2:0] h, input logic ovf);
        vec_t v;
        v.op = op; v.data = d; v.exp_word = w; v.exp_ti = ti; v.exp_held = h; v.exp_ovf = ovf;
        vecs.push_back(v);
    endfunction

    task automatic pulse_free();
        bus.tx_free = 1'b1;
        repeat (4) @(negedge clk);
        bus.tx_free = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_rrst();
        bus.rxFrameReset = 1'b1;
        repeat (4) @(negedge clk);
        bus.rxFrameReset = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic write_word(input logic [15:0] d);
        bus.traceValid = 1'b1;
        bus.traceWord  = d;
        @(negedge clk);
        bus.traceValid = 1'b0;
    endtask

    initial begin
        int h;
        int n;
        total = 0;
        bad   = 0;
        bus.traceWord    = '0;
        bus.traceValid   = 1'b0;
        bus.sync         = 1'b1;
        bus.tx_free      = 1'b0;
        bus.rxFrameReset = 1'b0;
        rst = 1'b0;

        // Fill and drain
        for (int i = 0; i < 8; i++)
            add(OP_WR, 16'(i + 1), (i == 7) ? 16'h0001 : 16'h0000, i == 7, (i == 7) ? 3'd1 : 3'd0, 1'b0);
        for (int k = 1; k <= 8; k++)
            add(OP_FREE, 16'h0, (k == 8) ? 16'h0008 : 16'(k + 1), k != 8, (k == 8) ? 3'd0 : 3'd1, 1'b0);
        // Reread
        for (int i = 0; i < 8; i++)
            add(OP_WR, 16'(i + 1), (i == 7) ? 16'h0001 : 16'h0008, i == 7, (i == 7) ? 3'd1 : 3'd0, 1'b0);
        for (int k = 1; k <= 3; k++)
            add(OP_FREE, 16'h0, 16'(k + 1), 1'b1, 3'd1, 1'b0);
        add(OP_RRST, 16'h0, 16'h0001, 1'b1, 3'd1, 1'b0);
        for (int k = 1; k <= 8; k++)
            add(OP_FREE, 16'h0, (k == 8) ? 16'h0008 : 16'(k + 1), k != 8, (k == 8) ? 3'd0 : 3'd1, 1'b0);
        // Overflow: five frames, the fifth is dropped
        for (int f = 1; f <= 5; f++)
            for (int i = 0; i < 8; i++) begin
                h = (i == 7) ? f : f - 1;
                if (h > 4) h = 4;
                add(OP_WR, 16'((f << 4) | i), (h > 0) ? 16'h0010 : 16'h0008, h > 0, 3'(h), f == 5);
            end
        for (n = 1; n <= 32; n++)
            add(OP_FREE, 16'h0, (n == 32) ? 16'h0047 : 16'((((n / 8) + 1) << 4) | (n % 8)),
                n != 32, 3'(4 - n / 8), 1'b1);
        // Sync loss mid-frame
        for (int i = 0; i < 5; i++)
            add(OP_WR, 16'(16'h0C00 + i), 16'h0047, 1'b0, 3'd0, 1'b1);
        add(OP_NOSYNC, 16'hDEAD, 16'h0047, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 8; i++)
            add(OP_WR, 16'(16'h0A00 + i), (i == 7) ? 16'h0A00 : 16'h0047, i == 7, (i == 7) ? 3'd1 : 3'd0, 1'b1);
        // Second frame behind it, then read the first up to its last word
        for (int i = 0; i < 8; i++)
            add(OP_WR, 16'(16'h0070 + i), 16'h0A00, 1'b1, (i == 7) ? 3'd2 : 3'd1, 1'b1);
        for (int k = 1; k <= 7; k++)
            add(OP_FREE, 16'h0, 16'(16'h0A00 + k), 1'b1, 3'd2, 1'b1);

        repeat (2) @(negedge clk);
        check("reset_tx_word", 32'(bus.tx_word), 32'h0);
        check("reset_transmitIn", 32'(bus.transmitIn), 32'h0);
        check("reset_overflow", 32'(bus.overflow), 32'h0);
        check("reset_framesHeld", 32'(bus.framesHeld), 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_WR:   write_word(vecs[i].data);
                OP_FREE: pulse_free();
                OP_RRST: pulse_rrst();
                default: begin
                    bus.sync       = 1'b0;
                    bus.traceValid = 1'b1;
                    bus.traceWord  = vecs[i].data;
                    @(negedge clk);
                    bus.sync       = 1'b1;
                    bus.traceValid = 1'b0;
                end
            endcase
            check($sformatf("v%0d_tx_word", i), 32'(bus.tx_word), 32'(vecs[i].exp_word));
            check($sformatf("v%0d_transmitIn", i), 32'(bus.transmitIn), 32'(vecs[i].exp_ti));
            check($sformatf("v%0d_framesHeld", i), 32'(bus.framesHeld), 32'(vecs[i].exp_held));
            check($sformatf("v%0d_overflow", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
        end

`ifdef TRACE_FRAME_BUFFER_STATS_EN
        check("stats_dropCount", 32'(bus.dropCount), 32'd1);
        check("stats_hwmFrames", 32'(bus.hwmFrames), 32'd4);
`endif

        // Commit of frame C lands on the same clk as the release of the last word of 0x0A frame
        for (int i = 0; i < 7; i++) write_word(16'(16'h0080 + i));
        check("conc_pre_held", 32'(bus.framesHeld), 32'd2);
        bus.tx_free = 1'b1;
        repeat (3) @(negedge clk);
        check("conc_before_edge_word", 32'(bus.tx_word), 32'h0A07);
        check("conc_before_edge_held", 32'(bus.framesHeld), 32'd2);
        write_word(16'h0087);
        check("conc_held", 32'(bus.framesHeld), 32'd2);
        check("conc_tx_word", 32'(bus.tx_word), 32'h0070);
        check("conc_transmitIn", 32'(bus.transmitIn), 32'd1);
        repeat (2) @(negedge clk);
        bus.tx_free = 1'b0;
        repeat (6) @(negedge clk);
        check("conc_after_held", 32'(bus.framesHeld), 32'd2);

        // Asynchronous reset in the middle of a write frame
        for (int i = 0; i < 3; i++) write_word(16'(16'h0090 + i));
        #2 rst = 1'b0;
        #1;
        check("arst_tx_word", 32'(bus.tx_word), 32'h0);
        check("arst_transmitIn", 32'(bus.transmitIn), 32'h0);
        check("arst_overflow", 32'(bus.overflow), 32'h0);
        check("arst_framesHeld", 32'(bus.framesHeld), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_arst_transmitIn", 32'(bus.transmitIn), 32'h0);
        check("post_arst_framesHeld", 32'(bus.framesHeld), 32'h0);
        for (int i = 0; i < 8; i++) write_word(16'(16'h00B0 + i));
        check("post_arst_frame_word", 32'(bus.tx_word), 32'h00B0);
        check("post_arst_frame_held", 32'(bus.framesHeld), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trace_frame_buffer.md
Name: trace_frame_buffer

Overview:
- Sits between the parallel-trace word assembler and the SPI slave link.
- Packs incoming 16-bit trace words into fixed frames of FRAME_WORDS words and holds up to DEPTH_FRAMES complete frames.
- Drives tx_word and transmitIn toward the SPI slave, and advances one word per tx_free pulse coming back from the SPI clock domain.
- Absorbs burstiness between the target's trace rate and host polling; drops whole frames on overflow, never partial ones.

Parameters:
FRAME_WORDS, 8, words per frame (16 octets); power of two, at least 2
DEPTH_FRAMES, 4, complete frames buffered; power of two, at least 2
ADDR_W, $clog2(FRAME_WORDS*DEPTH_FRAMES), storage address width (derived, not overridden)

Ports:
clk  in  1  system clock; the only clock
rst  in  1  asynchronous, active-low reset
traceWord  in  16  assembled trace word
traceValid  in  1  traceWord valid this cycle
sync  in  1  trace synchronised; low discards the in-progress write frame
tx_free  in  1  word-consumed pulse from the SPI slave, asynchronous (dClk domain)
rxFrameReset  in  1  restart current read frame, asynchronous (dClk domain)
tx_word  out  16  word at head of current read frame
transmitIn  out  1  at least one complete frame is available
overflow  out  1  sticky; a frame was dropped since reset
framesHeld  out  $clog2(DEPTH_FRAMES)+1  committed frames held

Behaviour:
- Reset values (async assert, sync deassert): tx_word=0, transmitIn=0, overflow=0, framesHeld=0, all pointers 0, synchroniser flops 0, dropping=0.
- Storage: FRAME_WORDS*DEPTH_FRAMES x 16 array; write address {wr_frame, wr_idx}, read address {rd_frame, rd_idx}.
- Write side, on traceValid && sync:
  - If wr_idx==0 and framesHeld==DEPTH_FRAMES, set dropping=1 and overflow=1; the whole frame is discarded.
  - Otherwise store the word (unless dropping) and increment wr_idx.
  - At wr_idx==FRAME_WORDS-1: wrap wr_idx to 0. If not dropping, commit the frame (wr_frame++, modulo wrap, framesHeld++). Clear dropping.
- sync low: wr_idx<=0 and dropping<=0 every cycle; traceValid is ignored. Committed frames are unaffected.
- Read side:
  - tx_free and rxFrameReset each pass through a 2-flop synchroniser plus a rising-edge detect. Each edge is one clk pulse, 3 clk after the input rises.
  - Free edge with framesHeld!=0: rd_idx++.
  - Free edge at rd_idx==FRAME_WORDS-1: rd_idx<=0, rd_frame++, framesHeld-- (release).
  - Free edge with framesHeld==0: ignored.
  - Reset edge: rd_idx<=0 and the current frame is retained. It takes priority over a same-cycle free edge.
- tx_word is registered from the read address and is valid 1 clk after any pointer change.
- transmitIn = (framesHeld!=0), registered.
- Latency: last word of a frame on cycle N gives transmitIn=1 on N+1.
- Simultaneous commit and release: framesHeld unchanged, both pointers advance.
- Full state: an already-started (non-dropping) frame still completes. Full is only checked at frame start, so a frame never overflows mid-frame.
- Empty state: transmitIn=0 and tx_word holds its last value.
- framesHeld never exceeds DEPTH_FRAMES and never underflows.

Optional Feature:
- Macro: TRACE_FRAME_BUFFER_STATS_EN.
- Defined:
  - Adds output dropCount[15:0], incremented once per dropped frame and saturating at 16'hFFFF; reset value 0.
  - Adds output hwmFrames, same width as framesHeld: the maximum framesHeld since reset.
- Undefined: neither port exists and overflow alone reports drops.

Decomposition:
- Shared package trace_pkg:
  - TRACE_WORD_W=16, FRAME_WORDS_DEFAULT=8, DEPTH_FRAMES_DEFAULT=4.
  - Width typedef for trace words.
  - Frame-header bit positions shared with the SPI slave (valid bit, width field, sync bit).
- One sub-module, pulse_sync: 2-flop synchroniser plus rising-edge detect, async active-low reset. It is instantiated twice (tx_free, rxFrameReset).

Test Plan:
- Fill: 8 words 16'h0001..16'h0008 with sync=1 -> transmitIn=1 one cycle after the 8th, tx_word=16'h0001, framesHeld=1.
- Drain: 8 tx_free pulses, each 4 clk wide and 10 clk apart -> tx_word steps 0001..0008, then transmitIn=0, framesHeld=0.
- Overflow: write 5 frames (tags 0x1x..0x5x) with no reads -> framesHeld=4, overflow=1; draining yields 0x1x..0x4x only. With STATS_EN, dropCount=1 and hwmFrames=4.
- Reread: after 3 tx_free pulses (tx_word=0004), pulse rxFrameReset -> tx_word=0001, framesHeld still 1.
- Sync loss: write 5 words, drop sync for 1 cycle, write 8 words 0x0A00..0x0A07 -> exactly one frame held, starting 0x0A00.
- Concurrency and reset: final write commit on the same clk as the final-word release with framesHeld=2 -> stays 2. Async rst mid-frame -> all outputs 0 immediately.
